// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int DEFAULT_WORD_LEN     = 32;
    localparam int DEFAULT_STARVE_LIMIT = 2;
    localparam int DEFAULT_CNT_W        = 2;

endpackage

// File: rtl/mem_arb_grant.sv
// Fetch/data grant selection with a bounded data-side preference.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    input  logic i_req_valid,
    input  logic d_req_valid,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    // Data wins unless fetch has already waited out its limit.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (d_req_valid && !(i_req_valid && (starve_cnt_q == LIMIT_C))) begin
            grant_d = 1'b1;
        end else if (i_req_valid) begin
            grant_i = 1'b1;
        end else begin
            grant_i = 1'b0;
        end
    end

    // Count data grants that bypass a waiting fetch; a fetch grant clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (idle && grant_i) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else if (idle && grant_d && i_req_valid && (starve_cnt_q != LIMIT_C)) begin
            starve_cnt_d = starve_cnt_q + ONE_C;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= {CNT_W{1'b0}};
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch and data ports,
// one transaction at a time, routing the response back to its owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_LEN     = DEFAULT_WORD_LEN,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [WORD_LEN-1:0] i_addr,
    output logic                i_resp_valid,
    output logic [WORD_LEN-1:0] i_rdata,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic                d_wen,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic                d_resp_valid,
    output logic [WORD_LEN-1:0] d_rdata,
    output logic                mem_cmd_valid,
    input  logic                mem_cmd_ready,
    output logic [WORD_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic                mem_resp_valid,
    input  logic [WORD_LEN-1:0] mem_rdata,
    output logic                resp_err
);

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [WORD_LEN-1:0] addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [WORD_LEN-1:0] wdata_q, wdata_d;
    logic                resp_err_q, resp_err_d;

    logic idle_s;
    logic grant_i_s;
    logic grant_d_s;

    assign idle_s = (state_q == ST_IDLE);

    mem_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_grant (
        .clk         (clk),
        .rst_n       (rst_n),
        .idle        (idle_s),
        .i_req_valid (i_req_valid),
        .d_req_valid (d_req_valid),
        .grant_i     (grant_i_s),
        .grant_d     (grant_d_s)
    );

    // Readies are also forced low while reset is held.
    assign i_req_ready = rst_n & idle_s & grant_i_s;
    assign d_req_ready = rst_n & idle_s & grant_d_s;

    assign mem_cmd_valid = (state_q == ST_CMD);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;

    assign i_resp_valid = (state_q == ST_RESP) & mem_resp_valid & (owner_q == OWN_I);
    assign d_resp_valid = (state_q == ST_RESP) & mem_resp_valid & (owner_q == OWN_D);
    assign i_rdata      = mem_rdata;
    assign d_rdata      = mem_rdata;
    assign resp_err     = resp_err_q;

    // Transaction FSM and command capture.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d_s) begin
                    state_d = ST_CMD;
                    owner_d = OWN_D;
                    addr_d  = d_addr;
                    wen_d   = d_wen;
                    wdata_d = d_wdata;
                end else if (grant_i_s) begin
                    state_d = ST_CMD;
                    owner_d = OWN_I;
                    addr_d  = i_addr;
                    wen_d   = 1'b0;
                    wdata_d = {WORD_LEN{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (mem_cmd_ready) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_RESP: begin
                if (mem_resp_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A response while no transaction is awaiting one is latched as an error.
    always_comb begin
        resp_err_d = resp_err_q;
        if (mem_resp_valid && (state_q != ST_RESP)) begin
            resp_err_d = 1'b1;
        end else begin
            resp_err_d = resp_err_q;
        end
    end

    // State and command holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_I;
            addr_q     <= {WORD_LEN{1'b0}};
            wen_q      <= 1'b0;
            wdata_q    <= {WORD_LEN{1'b0}};
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            resp_err_q <= resp_err_d;
        end
    end

endmodule
